lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_MATCHES, default 32: the number of consecutive correct predictions needed to declare lock.
REQ-002 The block SHALL have parameter LOSS_ERRORS, default 8: the number of errors within one window that forces loss of lock.
REQ-003 The block SHALL have parameter WINDOW, default 256: the length, in valid bits, of the error-counting window while locked.
REQ-004 Port clk, input, 1 bit: the clock; the block SHALL be fully synchronous to the rising edge of clk.
REQ-005 Port reset_n, input, 1 bit: the reset; it SHALL be synchronous and active-low.
REQ-006 Port bit_in, input, 1 bit: the received PRBS bit.
REQ-007 Port bit_valid, input, 1 bit: qualifies bit_in; the block SHALL do nothing on cycles where it is low, except for clear.
REQ-008 Port clear, input, 1 bit: SHALL synchronously zero err_count and bit_count.
REQ-009 Port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-010 Port err_pulse, output, 1 bit: a one-cycle strobe for each mismatched bit while locked.
REQ-011 Port err_count, output, 16 bits: total mismatches while locked; it SHALL saturate at 16'hFFFF.
REQ-012 Port bit_count, output, 32 bits: valid bits checked while locked; it SHALL wrap modulo 2^32.

Function
REQ-013 The block SHALL check against polynomial x^16+x^14+x^13+x^11+1.
- Local 16-bit register s.
- Prediction p = s[15]^s[13]^s[12]^s[10].
- Shift rule: s <= {s[14:0], x}, where x is the bit shifted in.
- Transmitted stream = successive feedback bits of a generator with the same shift rule.
REQ-014 The FSM SHALL have three states: HUNT, CHECK and LOCKED.
REQ-015 HUNT:
- Each valid bit: x = bit_in; a fill counter increments.
- After the 16th valid bit: go to CHECK with the match counter = 0.
REQ-016 CHECK:
- Each valid bit: x = bit_in (self-synchronising).
- If bit_in == p and s != 0: the match counter increments.
- Otherwise: the match counter clears to 0.
- When the match counter reaches LOCK_MATCHES: go to LOCKED; the window counter and window error counter clear.
REQ-017 An all-zero s SHALL never count as a match, so the checker cannot lock on an idle-zero line.
REQ-018 LOCKED:
- Each valid bit: x = p (free-running; received errors do not corrupt s).
- bit_count increments.
- If bit_in != p: err_pulse = 1 on the next cycle, err_count increments (saturating), and the window error counter increments.
REQ-019 The window counter SHALL count valid bits while LOCKED; on the bit that completes WINDOW bits, both the window counter and the window error counter clear.
REQ-020 If the window error counter reaches LOSS_ERRORS, the FSM SHALL go to HUNT with the fill counter = 0.
- This check takes priority over the window-end clear on the same bit.
- err_count keeps its value.
REQ-021 Timing of locked and err_pulse:
- locked SHALL be registered; it rises on the cycle after the valid bit that completes the match run.
- locked falls on the cycle after the error bit that triggers loss of lock.
- err_pulse SHALL be registered with one-cycle latency from the error bit.
REQ-022 Simultaneous clear and error:
- clear wins, so err_count = 0 and bit_count = 0 on the next cycle.
- err_pulse still fires.
- The window counters are unaffected by clear.
REQ-023 bit_valid low SHALL freeze s, the FSM state and all counters; err_pulse is 0 on those cycles.

Reset
REQ-024 With reset_n low at a clock edge, the block SHALL go to HUNT and set s = 16'h0000, all counters = 0, locked = 0, err_pulse = 0, err_count = 0 and bit_count = 0.
REQ-025 A reset asserted mid-lock SHALL take effect on that edge with no further err_pulse.

Structure
REQ-026 A shared package/include SHALL hold:
- the tap positions (15, 13, 12, 10);
- the generator seed 16'hACE1;
- the FSM state encoding (HUNT=0, CHECK=1, LOCKED=2).
REQ-027 A single sub-module lfsr16_step (combinational: s in, feedback bit out) SHALL be used.
- It is reused by the generator-side model in the bench.
- There are no other sub-modules.

Verification
REQ-028 Clean lock: stimulus is a generator seeded 16'hACE1 driving bit_valid = 1 continuously -> locked rises at the edge after valid bit 48 (16 + 32), and err_count stays 0 for 10000 bits.
REQ-029 Single error: one bit inverted while locked -> exactly one err_pulse, err_count = 1, locked stays 1, and no follow-on errors occur.
REQ-030 Loss of lock: 8 inverted bits within 256 valid bits -> locked falls the cycle after the 8th error and relock occurs 48 bits later; 7 errors per window, with the window boundary between bursts -> lock is retained.
REQ-031 Zero line: bit_in = 0 held for 1000 valid bits -> locked never asserts and the FSM stays in CHECK.
REQ-032 Gapped valid plus clear: bit_valid toggling 1/0 -> behaviour is identical to continuous input per valid bit; clear on the same cycle as an error bit -> err_count = 0 and err_pulse = 1.
REQ-033 Reset mid-lock: reset_n pulsed low for 1 cycle while locked -> all outputs are 0 the next cycle, and relock occurs after 48 bits.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// Shared constants for the x^16+x^14+x^13+x^11+1 PRBS checker:
// tap positions, generator seed and FSM state encoding.
package lfsr_checker_pkg;

   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   localparam logic [15:0] GEN_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/lfsr16_step.sv
// One step of the 16-bit Fibonacci LFSR: returns the feedback bit for state s.
module lfsr16_step
   import lfsr_checker_pkg::*;
(
   input  logic [15:0] s,
   output logic        fb
);

   assign fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: self-synchronises on the received stream, then free-runs its
// own LFSR while locked and counts mismatches, dropping lock on error bursts.
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int LOCK_MATCHES = 32,
   parameter int LOSS_ERRORS  = 8,
   parameter int WINDOW       = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        clear,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [31:0] bit_count
);

   localparam int MW = (LOCK_MATCHES > 1) ? $clog2(LOCK_MATCHES) : 1;
   localparam int EW = (LOSS_ERRORS > 1) ? $clog2(LOSS_ERRORS) : 1;
   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   localparam logic [3:0]    FILL_LAST  = 4'd15;
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
   localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERRORS - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);

   state_t        state;
   logic [15:0]   s;
   logic [3:0]    fill_cnt;
   logic [MW-1:0] match_cnt;
   logic [EW-1:0] win_err;
   logic [WW-1:0] win_cnt;
   logic          pred;
   logic          mismatch;

   lfsr16_step u_step (
      .s  (s),
      .fb (pred)
   );

   assign mismatch = (bit_in != pred);

   // While hunting/checking the register is fed from the line; once locked it
   // is fed from its own prediction so received errors cannot corrupt it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= HUNT;
         s         <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_err   <= '0;
         win_cnt   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (bit_valid) begin
            case (state)
               HUNT: begin
                  s <= {s[14:0], bit_in};
                  if (fill_cnt == FILL_LAST) begin
                     state     <= CHECK;
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 4'd1;
                  end
               end
               CHECK: begin
                  s <= {s[14:0], bit_in};
                  // An all-zero register predicts zero forever; never trust it.
                  if (!mismatch && (s != 16'h0000)) begin
                     if (match_cnt == MATCH_LAST) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                     end else begin
                        match_cnt <= match_cnt + MW'(1);
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  s         <= {s[14:0], pred};
                  bit_count <= bit_count + 32'd1;
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                     end
                  end
                  // Loss of lock outranks the window rollover on the same bit.
                  if (mismatch && (win_err == ERR_LAST)) begin
                     state    <= HUNT;
                     locked   <= 1'b0;
                     fill_cnt <= '0;
                  end else if (win_cnt == WIN_LAST) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + WW'(1);
                     if (mismatch) begin
                        win_err <= win_err + EW'(1);
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
         if (clear) begin
            err_count <= '0;
            bit_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: drives a seeded PRBS generator with
// optional bit inversions, gaps, clears and resets, checking outputs.
module tb_lfsr_checker;
   import lfsr_checker_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        bit_in;
   logic        bit_valid;
   logic        clear;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [31:0] bit_count;

   logic [15:0] gen;
   logic        step_fb;
   logic        zero_line;

   int total;
   int bad;
   int since_lock;
   int pulse_cnt;
   int lock_hi;
   int step_diff;

   lfsr_checker u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .bit_count (bit_count)
   );

   lfsr16_step u_gen_step (
      .s  (gen),
      .fb (step_fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_fb(input logic [15:0] v);
      return v[15] ^ v[13] ^ v[12] ^ v[10];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One valid bit; inv flips it, clr pulses clear, rst pulses reset_n low.
   task automatic applyStimulus(input logic inv, input logic clr, input logic rst);
      logic fb;
      @(negedge clk);
      fb = ref_fb(gen);
      if (step_fb !== fb) step_diff++;
      bit_in    = zero_line ? 1'b0 : (fb ^ inv);
      bit_valid = 1'b1;
      clear     = clr;
      reset_n   = ~rst;
      gen       = {gen[14:0], fb};
      since_lock++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      clear   = 1'b0;
      pulse_cnt += int'(err_pulse);
      lock_hi   += int'(locked);
   endtask

   task automatic idleCycle(input logic clr);
      @(negedge clk);
      bit_valid = 1'b0;
      clear     = clr;
      @(posedge clk);
      #1;
      clear = 1'b0;
      pulse_cnt += int'(err_pulse);
   endtask

   task automatic alignWindow();
      while ((since_lock % 256) != 0) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      total = 0; bad = 0; since_lock = 0; pulse_cnt = 0; lock_hi = 0; step_diff = 0;
      zero_line = 1'b0;
      gen       = GEN_SEED;
      reset_n   = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      clear     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_bit_count", bit_count, 32'd0);
      checkOutput("seed_feedback", 32'(step_fb), 32'd1);
      reset_n = 1'b1;

      $display("[TB] clean lock");
      repeat (47) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("lock_bit47", 32'(locked), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("lock_bit48", 32'(locked), 32'd1);
      checkOutput("lock_bit_count", bit_count, 32'd0);
      since_lock = 0; pulse_cnt = 0; lock_hi = 0;
      repeat (10000) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("clean_pulses", 32'(pulse_cnt), 32'd0);
      checkOutput("clean_err_count", 32'(err_count), 32'd0);
      checkOutput("clean_bit_count", bit_count, 32'd10000);
      checkOutput("clean_lock_held", 32'(lock_hi), 32'd10000);

      $display("[TB] single error");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("single_pulse", 32'(err_pulse), 32'd1);
      checkOutput("single_err_count", 32'(err_count), 32'd1);
      checkOutput("single_locked", 32'(locked), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("single_pulse_gone", 32'(err_pulse), 32'd0);
      pulse_cnt = 0;
      repeat (300) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("single_followon", 32'(pulse_cnt), 32'd0);
      checkOutput("single_err_hold", 32'(err_count), 32'd1);

      $display("[TB] seven errors per window");
      alignWindow();
      pulse_cnt = 0;
      repeat (100) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (7) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (149) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (7) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("seven_locked", 32'(locked), 32'd1);
      checkOutput("seven_pulses", 32'(pulse_cnt), 32'd14);
      checkOutput("seven_err_count", 32'(err_count), 32'd15);

      $display("[TB] loss of lock");
      alignWindow();
      for (int k = 1; k <= 8; k++) begin
         repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (k == 7) checkOutput("loss_after7", 32'(locked), 32'd1);
      end
      checkOutput("loss_after8", 32'(locked), 32'd0);
      checkOutput("loss_pulse", 32'(err_pulse), 32'd1);
      checkOutput("loss_err_count", 32'(err_count), 32'd23);
      repeat (47) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("relock_bit47", 32'(locked), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("relock_bit48", 32'(locked), 32'd1);
      checkOutput("relock_err_count", 32'(err_count), 32'd23);
      since_lock = 0;

      $display("[TB] clear with error");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("clr_err_pulse", 32'(err_pulse), 32'd1);
      checkOutput("clr_err_count", 32'(err_count), 32'd0);
      checkOutput("clr_bit_count", bit_count, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("clr_next_bit_count", bit_count, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("clr_err_again", 32'(err_count), 32'd1);
      idleCycle(1'b0);
      checkOutput("idle_pulse", 32'(err_pulse), 32'd0);
      checkOutput("idle_bit_count", bit_count, 32'd2);
      idleCycle(1'b1);
      checkOutput("idle_clr_err", 32'(err_count), 32'd0);
      checkOutput("idle_clr_bits", bit_count, 32'd0);

      $display("[TB] reset mid-lock and gapped relock");
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rstlock_locked", 32'(locked), 32'd0);
      checkOutput("rstlock_pulse", 32'(err_pulse), 32'd0);
      checkOutput("rstlock_err_count", 32'(err_count), 32'd0);
      checkOutput("rstlock_bit_count", bit_count, 32'd0);
      for (int i = 0; i < 47; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         idleCycle(1'b0);
      end
      checkOutput("gap_bit47", 32'(locked), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("gap_bit48", 32'(locked), 32'd1);
      idleCycle(1'b0);
      checkOutput("gap_hold_lock", 32'(locked), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("gap_err_pulse", 32'(err_pulse), 32'd1);
      idleCycle(1'b0);
      checkOutput("gap_pulse_idle", 32'(err_pulse), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("gap_err_count", 32'(err_count), 32'd1);
      checkOutput("gap_bit_count", bit_count, 32'd2);

      $display("[TB] zero line");
      zero_line = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      lock_hi = 0;
      repeat (1000) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("zero_never_lock", 32'(lock_hi), 32'd0);
      checkOutput("zero_state", 32'(u_dut.state), 32'(CHECK));
      checkOutput("gen_step_agree", 32'(step_diff), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
